event_dispatcher: RTL and testbench

Parametrised event ingress stage in front of the aegnn_hw core.
- Buffers incoming DVS events (p, x, y, t, addr) in a FIFO.
- Filters out-of-range and out-of-order events.
- Issues each surviving event to the core as a one-cycle data_valid pulse, gated by the core's module_ready.
- Holds the event stable until module_done returns.

---
 rtl/event_dispatcher.sv | 150 +++++++++++++++
 tb/tb_event_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_dispatcher.sv
// event_dispatcher: DVS event FIFO, range/order filter and issue FSM for the aegnn_hw core (rev 1.0).
// Optional feature macro: EVT_TS_WRAP_EN (wrap-aware timestamp ordering and ts_wrap strobe).
`default_nettype none

module event_dispatcher #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int T_W      = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 8,
  parameter int SENSOR_W = 128,
  parameter int SENSOR_H = 128
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_p,
  input  logic [X_W-1:0]                    in_x,
  input  logic [Y_W-1:0]                    in_y,
  input  logic [T_W-1:0]                    in_t,
  input  logic [ADDR_W-1:0]                 in_addr,
  input  logic                              module_ready,
  input  logic                              module_done,
  output logic                              data_valid,
  output logic [X_W+Y_W+T_W+ADDR_W+1:0]     new_event,
  output logic [$clog2(DEPTH):0]            fifo_count,
  output logic [15:0]                       drop_cnt,
  output logic                              busy,
  output logic                              ts_wrap
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + X_W + Y_W + T_W + ADDR_W;
  localparam logic [X_W:0] C_SW    = (X_W+1)'(SENSOR_W);
  localparam logic [Y_W:0] C_SH    = (Y_W+1)'(SENSOR_H);
  localparam logic [PW:0]  C_DEPTH = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q, count_d;
  logic          in_ready_q;
  logic [T_W-1:0] last_t_q;
  logic          first_seen_q;
  logic [15:0]   drop_cnt_q;
  logic [EW:0]   new_event_q;

  logic accept, x_bad, y_bad, ooo, drop, push, drop_ev, pop;

  assign accept = in_valid && in_ready_q;
  assign x_bad  = ({1'b0, in_x} >= C_SW);
  assign y_bad  = ({1'b0, in_y} >= C_SH);

`ifdef EVT_TS_WRAP_EN
  logic [T_W-1:0] t_diff;
  logic           ts_wrap_q;
  // Half-range rule: a forward distance of 2^(T_W-1) or more means the event is older.
  assign t_diff  = in_t - last_t_q;
  assign ooo     = first_seen_q && t_diff[T_W-1];
  assign ts_wrap = ts_wrap_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts_wrap_q <= 1'b0;
    else       ts_wrap_q <= push && (in_t < last_t_q);
  end
`else
  assign ooo     = first_seen_q && (in_t < last_t_q);
  assign ts_wrap = 1'b0;
`endif

  assign drop    = x_bad || y_bad || ooo;
  assign push    = accept && !drop;
  assign drop_ev = accept && drop;
  // Pop looks only at registered occupancy, so a same-cycle write is never bypassed.
  assign pop     = (state_q == IDLE) && (count_q != '0) && module_ready;
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

  assign in_ready   = in_ready_q;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_cnt_q;
  assign new_event  = new_event_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_p, in_x, in_y, in_t, in_addr};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      last_t_q     <= '0;
      first_seen_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != C_DEPTH);
      if (push) begin
        wptr_q       <= wptr_q + PW'(1);
        last_t_q     <= in_t;
        first_seen_q <= 1'b1;
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (drop_ev && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      new_event_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop)
        new_event_q <= {1'b1, mem_q[rptr_q]};
      else if ((state_d == IDLE) && (state_q != IDLE))
        new_event_q[EW] <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pop) state_d = ISSUE;
      end
      ISSUE: begin
        data_valid = 1'b1;
        state_d    = module_done ? IDLE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (module_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_event_dispatcher.sv
// Directed bench for event_dispatcher (T_W=16); honours EVT_TS_WRAP_EN when defined.
`default_nettype none

module tb_event_dispatcher;

  localparam int T_W = 16;
`ifdef EVT_TS_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_p;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [15:0] in_t;
  logic [31:0] in_addr;
  logic        module_ready;
  logic        module_done;
  logic        data_valid;
  logic [65:0] new_event;
  logic [3:0]  fifo_count;
  logic [15:0] drop_cnt;
  logic        busy;
  logic        ts_wrap;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [15:0] log_t[$];
  int          log_c[$];
  logic        rdy;
  int          nt;

  always #5 clk = ~clk;

  event_dispatcher #(.T_W(T_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_x(in_x), .in_y(in_y), .in_t(in_t), .in_addr(in_addr),
    .module_ready(module_ready), .module_done(module_done),
    .data_valid(data_valid), .new_event(new_event),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt),
    .busy(busy), .ts_wrap(ts_wrap)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && data_valid) begin
      log_t.push_back(new_event[47:32]);
      log_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] t, input logic [31:0] a);
    in_valid = 1'b1;
    in_p     = p;
    in_x     = x;
    in_y     = y;
    in_t     = t;
    in_addr  = a;
  endtask

  function automatic logic [65:0] ev(input logic v, input logic p, input logic [7:0] x,
                                     input logic [7:0] y, input logic [15:0] t,
                                     input logic [31:0] a);
    return {v, p, x, y, t, a};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_p = 1'b0; in_x = '0; in_y = '0; in_t = '0;
    in_addr = '0; module_ready = 1'b0; module_done = 1'b0;

    // Reset state
    repeat (200) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_new_event", new_event, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ts_wrap", ts_wrap, 0);
    rstn = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Basic issue, done three cycles after the strobe
    module_ready = 1'b1;
    drive(1'b1, 8'd0, 8'd0, 16'd0, 32'hD00DB00F);
    tick();
    in_valid = 1'b0;
    chk("b_count_after_write", fifo_count, 1);
    chk("b_no_bypass", data_valid, 0);
    tick();
    chk("b_dv_pulse", data_valid, 1);
    chk("b_event", new_event, ev(1, 1, 0, 0, 0, 32'hD00DB00F));
    chk("b_busy", busy, 1);
    tick();
    chk("b_dv_single", data_valid, 0);
    tick();
    tick();
    module_done = 1'b1;
    chk("b_event_held", new_event, ev(1, 1, 0, 0, 0, 32'hD00DB00F));
    chk("b_busy_wait", busy, 1);
    tick();
    module_done = 1'b0;
    chk("b_valid_clear", new_event[65], 0);
    chk("b_idle", busy, 0);
    chk("b_dv_count", log_t.size(), 1);
    chk("b_drop_cnt", drop_cnt, 0);

    // Ordering and backpressure
    module_ready = 1'b0;
    log_t.delete(); log_c.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 8'(i), 8'(i), 16'(i), 32'hA000 + i);
      tick();
      if (i == 7) chk("o_ready_at7", in_ready, 1);
    end
    chk("o_ready_full", in_ready, 0);
    chk("o_count_full", fifo_count, 8);
    drive(1'b0, 8'd9, 8'd9, 16'd9, 32'hA009);
    tick();
    tick();
    chk("o_ninth_waits", fifo_count, 8);
    chk("o_ready_still_low", in_ready, 0);
    module_ready = 1'b1;
    module_done  = 1'b1;
    for (int k = 0; k < 60 && log_t.size() < 9; k++) begin
      rdy = in_ready;
      tick();
      if (rdy && in_valid) in_valid = 1'b0;
    end
    chk("o_issue_count", log_t.size(), 9);
    for (int j = 0; j < 9; j++)
      chk("o_order", (log_t.size() > j) ? log_t[j] : 16'hxxxx, 16'(j + 1));
    for (int j = 1; j < 9; j++)
      chk("o_spacing", (log_c.size() > j) ? (log_c[j] - log_c[j-1]) : -1, 2);
    repeat (2) tick();
    chk("o_drained", fifo_count, 0);

    // Filtering
    log_t.delete(); log_c.delete();
    drive(1'b0, 8'd200, 8'd1, 16'd10, 32'hB001);
    tick();
    chk("f_range_not_written", fifo_count, 0);
    drive(1'b0, 8'd1, 8'd1, 16'd5, 32'hB002);
    tick();
    drive(1'b0, 8'd3, 8'd3, 16'd9, 32'hB003);
    tick();
    in_valid = 1'b0;
    chk("f_drop_cnt", drop_cnt, 2);
    repeat (4) tick();
    chk("f_issued_once", log_t.size(), 1);
    chk("f_equal_t_kept", (log_t.size() > 0) ? log_t[0] : 16'hxxxx, 9);

    // Asynchronous reset while waiting for done
    module_ready = 1'b0;
    module_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd2, 8'd2, 16'(20 + i), 32'hC000 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("r_count_pre", fifo_count, 4);
    module_ready = 1'b1;
    tick();
    module_ready = 1'b0;
    tick();
    chk("r_busy_wait", busy, 1);
    chk("r_queued", fifo_count, 3);
    log_t.delete(); log_c.delete();
    #2 rstn = 1'b0;
    #1;
    chk("r_in_ready", in_ready, 0);
    chk("r_dv", data_valid, 0);
    chk("r_event", new_event, 0);
    chk("r_count", fifo_count, 0);
    chk("r_busy", busy, 0);
    chk("r_drop", drop_cnt, 0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("r_ready_back", in_ready, 1);
    module_ready = 1'b1;
    module_done  = 1'b1;
    drive(1'b0, 8'd5, 8'd5, 16'd0, 32'hC100);
    tick();
    in_valid = 1'b0;
    chk("r_t0_accepted", fifo_count, 1);
    chk("r_t0_not_dropped", drop_cnt, 0);
    repeat (4) tick();
    chk("r_issue_after", log_t.size(), 1);
    chk("r_issue_t", (log_t.size() > 0) ? log_t[0] : 16'hxxxx, 0);

    // Simultaneous push and pop, then push refused when full
    module_ready = 1'b0;
    nt = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd4, 8'd4, 16'(nt), 32'hE000 + nt);
      nt++;
      tick();
    end
    in_valid = 1'b0;
    chk("s_count4", fifo_count, 4);
    module_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (!busy) begin
        drive(1'b0, 8'd4, 8'd4, 16'(nt), 32'hE000 + nt);
        nt++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("s_count_steady", fifo_count, 4);
    end
    module_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd4, 8'd4, 16'(nt), 32'hE000 + nt);
      nt++;
      tick();
    end
    chk("s_full", fifo_count, 8);
    chk("s_full_ready", in_ready, 0);
    module_ready = 1'b1;
    drive(1'b0, 8'd4, 8'd4, 16'(nt), 32'hEFFF);
    tick();
    in_valid = 1'b0;
    chk("s_push_refused", fifo_count, 7);
    for (int k = 0; k < 60 && (fifo_count != 0 || busy); k++) tick();
    chk("s_drain_count", fifo_count, 0);
    chk("s_drain_idle", busy, 0);

    // Timestamp wrap
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    drive(1'b0, 8'd1, 8'd1, 16'd65530, 32'hF001);
    tick();
    chk("w_no_wrap_first", ts_wrap, 0);
    drive(1'b0, 8'd1, 8'd1, 16'd4, 32'hF002);
    tick();
    in_valid = 1'b0;
    chk("w_wrap_strobe", ts_wrap, WRAP);
    chk("w_drop_cnt", drop_cnt, WRAP ? 16'd0 : 16'd1);
    tick();
    chk("w_wrap_single", ts_wrap, 0);
    repeat (6) tick();
    chk("w_drained", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
